// File: rtl/p2_mem_arb_if.sv
// Bus bundle for p2_mem_arb: CPU and video request ports, the memory command/response port, and status.
// The slave modport is the arbiter's view; the master modport is the view of whatever surrounds it.
interface p2_mem_arb_if #(
    parameter int unsigned ADDR_W = 22
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    logic              cpu_req;
    logic              cpu_we;
    logic [BE_W-1:0]   cpu_be;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_rdata;

    logic              mem_req;
    logic              mem_we;
    logic              mem_ref;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        owner;
    logic              ref_overrun;

    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  vid_req, vid_addr,
        output vid_ack, vid_rdata,
        output mem_req, mem_we, mem_ref, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata,
        output owner, ref_overrun
    );

    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output vid_req, vid_addr,
        input  vid_ack, vid_rdata,
        input  mem_req, mem_we, mem_ref, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata,
        input  owner, ref_overrun
    );
endinterface

// File: rtl/p2_mem_arb.sv
// P2 memory arbiter: round-robin CPU/video access with optional periodic refresh.
// Define P2_MEM_ARB_REFRESH_EN to build the refresh counter and REF state.
module p2_mem_arb #(
    parameter int unsigned ADDR_W           = 22,
    parameter int unsigned REFRESH_INTERVAL = 624
) (
    input  logic          clk,
    input  logic          reset_n,
    p2_mem_arb_if.slave   bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    if (REFRESH_INTERVAL < 2) begin : g_bad_interval
        $error("p2_mem_arb: REFRESH_INTERVAL must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_VID  = 2'd2,
        ST_REF  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_ref_q, mem_ref_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                vid_ack_q, vid_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;
    logic                last_vid_q, last_vid_d;
    logic                ref_pend;
    logic                ref_ovr;
    logic                cpu_go;
    logic                vid_go;

    // A requester still shows req during its own ack cycle; mask it so one request yields one ack.
    assign cpu_go = bus.cpu_req && !cpu_ack_q;
    assign vid_go = bus.vid_req && !vid_ack_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_ref_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            last_vid_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_ref_q   <= mem_ref_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_ack_q   <= vid_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
            last_vid_q  <= last_vid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_ref_d   = mem_ref_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        last_vid_d  = last_vid_q;

        case (state_q)
            ST_IDLE: begin
                if (ref_pend) begin
                    state_d     = ST_REF;
                    mem_req_d   = 1'b1;
                    mem_ref_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end else if (cpu_go && (!vid_go || last_vid_q)) begin
                    state_d     = ST_CPU;
                    mem_req_d   = 1'b1;
                    mem_ref_d   = 1'b0;
                    mem_we_d    = bus.cpu_we;
                    mem_be_d    = bus.cpu_be;
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_wdata;
                    last_vid_d  = 1'b0;
                end else if (vid_go) begin
                    state_d     = ST_VID;
                    mem_req_d   = 1'b1;
                    mem_ref_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 2'b11;
                    mem_addr_d  = bus.vid_addr;
                    mem_wdata_d = '0;
                    last_vid_d  = 1'b1;
                end
            end
            ST_CPU: begin
                if (bus.mem_ack) begin
                    state_d     = ST_IDLE;
                    mem_req_d   = 1'b0;
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = bus.mem_rdata;
                end
            end
            ST_VID: begin
                if (bus.mem_ack) begin
                    state_d     = ST_IDLE;
                    mem_req_d   = 1'b0;
                    vid_ack_d   = 1'b1;
                    vid_rdata_d = bus.mem_rdata;
                end
            end
            ST_REF: begin
                if (bus.mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
        endcase
    end

`ifdef P2_MEM_ARB_REFRESH_EN
    localparam int unsigned CNT_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;

    logic [CNT_W-1:0] ref_cnt_q;
    logic             ref_pend_q;
    logic             ref_ovr_q;
    logic             enter_ref;

    assign enter_ref = (state_q == ST_IDLE) && (state_d == ST_REF);

    // A fresh expiry wins over the clear on REF entry; overrun only if the old request was still unserved.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt_q  <= CNT_W'(REFRESH_INTERVAL - 1);
            ref_pend_q <= 1'b0;
            ref_ovr_q  <= 1'b0;
        end else if (ref_cnt_q == '0) begin
            ref_cnt_q  <= CNT_W'(REFRESH_INTERVAL - 1);
            ref_pend_q <= 1'b1;
            if (ref_pend_q && !enter_ref) begin
                ref_ovr_q <= 1'b1;
            end
        end else begin
            ref_cnt_q <= ref_cnt_q - CNT_W'(1);
            if (enter_ref) begin
                ref_pend_q <= 1'b0;
            end
        end
    end

    assign ref_pend = ref_pend_q;
    assign ref_ovr  = ref_ovr_q;
`else
    assign ref_pend = 1'b0;
    assign ref_ovr  = 1'b0;
`endif

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_ref     = mem_ref_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.vid_ack     = vid_ack_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.vid_rdata   = vid_rdata_q;
    assign bus.owner       = 2'(state_q);
    assign bus.ref_overrun = ref_ovr;
endmodule

// File: tb/tb_p2_mem_arb.sv
// Directed bench for p2_mem_arb; the memory side is driven by hand with hand-computed expectations.
// With P2_MEM_ARB_REFRESH_EN defined it runs the refresh scenarios at an interval of 16.
module tb_p2_mem_arb;
    localparam int unsigned ADDR_W = 22;
`ifdef P2_MEM_ARB_REFRESH_EN
    localparam int unsigned RI = 16;
`else
    localparam int unsigned RI = 624;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    p2_mem_arb_if #(.ADDR_W(ADDR_W)) bus();

    p2_mem_arb #(.ADDR_W(ADDR_W), .REFRESH_INTERVAL(RI)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_be    = 2'b00;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle_inputs();
        #2;
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.mem_ref, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin
            miscompares++;
            $display("FAIL reset_mem: got req=%b we=%b ref=%b addr=%h wdata=%h be=%b required all 0",
                     bus.mem_req, bus.mem_we, bus.mem_ref, bus.mem_addr, bus.mem_wdata, bus.mem_be);
        end
        vectors++;
        if ({bus.cpu_ack, bus.vid_ack, bus.cpu_rdata, bus.vid_rdata, bus.owner, bus.ref_overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_req: got cack=%b vack=%b crd=%h vrd=%h owner=%0d ovr=%b required all 0",
                     bus.cpu_ack, bus.vid_ack, bus.cpu_rdata, bus.vid_rdata, bus.owner, bus.ref_overrun);
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_cpu_read;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_be   = 2'b11;
        bus.cpu_addr = 22'h000123;
        tick();
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.mem_ref, bus.mem_be} !== 5'b10011) begin
            miscompares++;
            $display("FAIL rd_cmd: got req/we/ref/be=%b required 10011",
                     {bus.mem_req, bus.mem_we, bus.mem_ref, bus.mem_be});
        end
        vectors++;
        if (bus.mem_addr !== 22'h000123 || bus.owner !== 2'd1) begin
            miscompares++;
            $display("FAIL rd_addr: got addr=%h owner=%0d required 000123 owner=1", bus.mem_addr, bus.owner);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hA55A;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.cpu_req   = 1'b0;
        vectors++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'hA55A) begin
            miscompares++;
            $display("FAIL rd_ack: got ack=%b rdata=%h required ack=1 rdata=a55a", bus.cpu_ack, bus.cpu_rdata);
        end
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.owner !== 2'd0 || bus.vid_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_done: got mem_req=%b owner=%0d vack=%b required 0 0 0",
                     bus.mem_req, bus.owner, bus.vid_ack);
        end
        tick();
        vectors++;
        if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 16'hA55A) begin
            miscompares++;
            $display("FAIL rd_pulse: got ack=%b rdata=%h required ack=0 rdata=a55a", bus.cpu_ack, bus.cpu_rdata);
        end
    endtask

    task automatic test_write;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_be    = 2'b01;
        bus.cpu_addr  = 22'h001020;
        bus.cpu_wdata = 16'h5AA5;
        tick();
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 4'b1101 || bus.mem_wdata !== 16'h5AA5
            || bus.mem_addr !== 22'h001020) begin
            miscompares++;
            $display("FAIL wr_cmd: got req/we/be=%b wdata=%h addr=%h required 1101 5aa5 001020",
                     {bus.mem_req, bus.mem_we, bus.mem_be}, bus.mem_wdata, bus.mem_addr);
        end
        bus.cpu_wdata = 16'hFFFF;
        bus.cpu_addr  = 22'h3FFFFF;
        tick();
        tick();
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.mem_wdata !== 16'h5AA5 || bus.mem_addr !== 22'h001020
            || bus.owner !== 2'd1) begin
            miscompares++;
            $display("FAIL wr_stable: got req=%b wdata=%h addr=%h owner=%0d required 1 5aa5 001020 1",
                     bus.mem_req, bus.mem_wdata, bus.mem_addr, bus.owner);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        vectors++;
        if (bus.cpu_ack !== 1'b1 || bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_ack: got ack=%b mem_req=%b required 1 0", bus.cpu_ack, bus.mem_req);
        end
        tick();
    endtask

    task automatic test_tie;
        do_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_be   = 2'b11;
        bus.cpu_addr = 22'h000100;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 22'h000200;
        tick();
        vectors++;
        if (bus.owner !== 2'd1 || bus.mem_addr !== 22'h000100) begin
            miscompares++;
            $display("FAIL tie_first: got owner=%0d addr=%h required 1 000100", bus.owner, bus.mem_addr);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h1111;
        tick();
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        vectors++;
        if (bus.owner !== 2'd0 || bus.cpu_ack !== 1'b1 || bus.vid_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_gap1: got owner=%0d cack=%b vack=%b required 0 1 0",
                     bus.owner, bus.cpu_ack, bus.vid_ack);
        end
        tick();
        vectors++;
        if (bus.owner !== 2'd2 || bus.mem_addr !== 22'h000200 || bus.mem_be !== 2'b11
            || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_second: got owner=%0d addr=%h be=%b we=%b required 2 000200 11 0",
                     bus.owner, bus.mem_addr, bus.mem_be, bus.mem_we);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h2222;
        tick();
        bus.mem_ack = 1'b0;
        bus.vid_req = 1'b0;
        vectors++;
        if (bus.owner !== 2'd0 || bus.vid_ack !== 1'b1 || bus.vid_rdata !== 16'h2222
            || bus.cpu_rdata !== 16'h1111) begin
            miscompares++;
            $display("FAIL tie_gap2: got owner=%0d vack=%b vrd=%h crd=%h required 0 1 2222 1111",
                     bus.owner, bus.vid_ack, bus.vid_rdata, bus.cpu_rdata);
        end
        tick();
        // Video was served last, so the next tie goes to the CPU again
        bus.cpu_req = 1'b1;
        bus.vid_req = 1'b1;
        tick();
        vectors++;
        if (bus.owner !== 2'd1) begin
            miscompares++;
            $display("FAIL tie_rr: got owner=%0d required 1", bus.owner);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        tick();
        vectors++;
        if (bus.owner !== 2'd2) begin
            miscompares++;
            $display("FAIL tie_rr2: got owner=%0d required 2", bus.owner);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.vid_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_be   = 2'b10;
        bus.cpu_addr = 22'h000003;
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h0101;
        tick();
        bus.mem_ack = 1'b0;
        vectors++;
        if (bus.cpu_ack !== 1'b1 || bus.owner !== 2'd0) begin
            miscompares++;
            $display("FAIL b2b_ack1: got ack=%b owner=%0d required 1 0", bus.cpu_ack, bus.owner);
        end
        tick();
        vectors++;
        if (bus.owner !== 2'd0 || bus.mem_req !== 1'b0 || bus.cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_nogrant: got owner=%0d mem_req=%b ack=%b required 0 0 0",
                     bus.owner, bus.mem_req, bus.cpu_ack);
        end
        tick();
        vectors++;
        if (bus.owner !== 2'd1 || bus.mem_req !== 1'b1 || bus.mem_be !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_grant2: got owner=%0d mem_req=%b be=%b required 1 1 10",
                     bus.owner, bus.mem_req, bus.mem_be);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h0202;
        tick();
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        vectors++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'h0202) begin
            miscompares++;
            $display("FAIL b2b_ack2: got ack=%b rdata=%h required 1 0202", bus.cpu_ack, bus.cpu_rdata);
        end
        tick();
    endtask

    task automatic test_drop_req;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 22'h3FFFFF;
        tick();
        vectors++;
        if (bus.owner !== 2'd2 || bus.mem_addr !== 22'h3FFFFF) begin
            miscompares++;
            $display("FAIL drop_grant: got owner=%0d addr=%h required 2 3fffff", bus.owner, bus.mem_addr);
        end
        bus.vid_req = 1'b0;
        tick();
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.owner !== 2'd2) begin
            miscompares++;
            $display("FAIL drop_hold: got mem_req=%b owner=%0d required 1 2", bus.mem_req, bus.owner);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        bus.mem_ack = 1'b0;
        vectors++;
        if (bus.vid_ack !== 1'b1 || bus.vid_rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL drop_ack: got vack=%b vrd=%h required 1 beef", bus.vid_ack, bus.vid_rdata);
        end
        tick();
        vectors++;
        if (bus.vid_ack !== 1'b0 || bus.owner !== 2'd0) begin
            miscompares++;
            $display("FAIL drop_after: got vack=%b owner=%0d required 0 0", bus.vid_ack, bus.owner);
        end
    endtask

    task automatic test_no_refresh;
        int bad;
        bad = 0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (bus.mem_req !== 1'b0 || bus.mem_ref !== 1'b0 || bus.owner !== 2'd0) bad++;
        end
        vectors++;
        if (bad !== 0 || bus.ref_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL no_refresh: got %0d busy cycles ovr=%b required 0 0", bad, bus.ref_overrun);
        end
    endtask

    task automatic test_reset_mid_cycle;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 22'h000055;
        tick();
        vectors++;
        if (bus.mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_start: got mem_req=%b required 1", bus.mem_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_be, bus.owner} !== '0) begin
            miscompares++;
            $display("FAIL mid_async: got req=%b addr=%h be=%b owner=%0d required all 0",
                     bus.mem_req, bus.mem_addr, bus.mem_be, bus.owner);
        end
        bus.cpu_req = 1'b0;
        tick();
        reset_n       = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h1234;
        tick();
        bus.mem_ack = 1'b0;
        vectors++;
        if (bus.cpu_ack !== 1'b0 || bus.vid_ack !== 1'b0 || bus.cpu_rdata !== 16'h0000
            || bus.owner !== 2'd0 || bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_stray: got cack=%b vack=%b crd=%h owner=%0d req=%b required 0 0 0000 0 0",
                     bus.cpu_ack, bus.vid_ack, bus.cpu_rdata, bus.owner, bus.mem_req);
        end
        tick();
        vectors++;
        if (bus.cpu_ack !== 1'b0 || bus.owner !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_after: got cack=%b owner=%0d required 0 0", bus.cpu_ack, bus.owner);
        end
    endtask

    task automatic test_refresh_idle;
        int exp_cyc;
        int n;
        do_reset();
        exp_cyc = 17;
        n       = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus.mem_req === 1'b1) begin
                vectors++;
                if (i != exp_cyc || bus.mem_ref !== 1'b1 || bus.owner !== 2'd3 || bus.mem_we !== 1'b0
                    || bus.mem_be !== 2'b00 || bus.mem_addr !== '0) begin
                    miscompares++;
                    $display("FAIL ref_pulse: got cycle=%0d ref=%b owner=%0d we=%b be=%b addr=%h required cycle=%0d 1 3 0 00 0",
                             i, bus.mem_ref, bus.owner, bus.mem_we, bus.mem_be, bus.mem_addr, exp_cyc);
                end
                n++;
                exp_cyc += 16;
                bus.mem_ack = 1'b1;
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
        bus.mem_ack = 1'b0;
        vectors++;
        if (n != 3 || bus.ref_overrun !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.vid_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ref_count: got %0d refreshes ovr=%b required 3 0", n, bus.ref_overrun);
        end
    endtask

    task automatic test_refresh_overrun;
        do_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_be   = 2'b11;
        bus.cpu_addr = 22'h000010;
        tick();
        for (int i = 2; i <= 41; i++) begin
            tick();
            if (i == 20) begin
                vectors++;
                if (bus.ref_overrun !== 1'b0 || bus.owner !== 2'd1) begin
                    miscompares++;
                    $display("FAIL ovr_early: got ovr=%b owner=%0d required 0 1", bus.ref_overrun, bus.owner);
                end
            end
        end
        vectors++;
        if (bus.ref_overrun !== 1'b1 || bus.owner !== 2'd1 || bus.mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_set: got ovr=%b owner=%0d req=%b required 1 1 1",
                     bus.ref_overrun, bus.owner, bus.mem_req);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        vectors++;
        if (bus.cpu_ack !== 1'b1 || bus.owner !== 2'd0) begin
            miscompares++;
            $display("FAIL ovr_cpuack: got ack=%b owner=%0d required 1 0", bus.cpu_ack, bus.owner);
        end
        tick();
        vectors++;
        if (bus.owner !== 2'd3 || bus.mem_ref !== 1'b1 || bus.mem_req !== 1'b1 || bus.cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_ref: got owner=%0d ref=%b req=%b ack=%b required 3 1 1 0",
                     bus.owner, bus.mem_ref, bus.mem_req, bus.cpu_ack);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        vectors++;
        if (bus.owner !== 2'd0 || bus.cpu_ack !== 1'b0 || bus.vid_ack !== 1'b0 || bus.ref_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_end: got owner=%0d cack=%b vack=%b ovr=%b required 0 0 0 1",
                     bus.owner, bus.cpu_ack, bus.vid_ack, bus.ref_overrun);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
`ifdef P2_MEM_ARB_REFRESH_EN
        test_refresh_idle();
        test_refresh_overrun();
`else
        test_tie();
        test_cpu_read();
        test_write();
        test_back_to_back();
        test_drop_req();
        test_no_refresh();
        test_reset_mid_cycle();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
